// File: rtl/down_counter_4_if.sv
// Control/status bundle for down_counter_4: the master drives the count
// controls, the slave returns the count and status flags.
interface down_counter_4_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             periodic;
  logic [WIDTH-1:0] q;
  logic             bo;
  logic             done;
  logic             running;

  modport master (
    output en, load, d, periodic,
    input  q, bo, done, running
  );

  modport slave (
    input  en, load, d, periodic,
    output q, bo, done, running
  );
endinterface

// File: rtl/down_counter_4.sv
// Loadable down counter built from JK toggle stages with a borrow AND-chain,
// supporting one-shot and auto-reload (periodic) modes.
module down_counter_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_4_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic             running_r;
  logic             done_r;

  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic [WIDTH-1:0] low_zero;
  logic             q_zero;
  logic             armed;
  logic             terminal;
  logic             count_step;
  logic             toggle0;
  logic             d_nonzero;

  assign q_zero     = (q_r == '0);
  assign armed      = bus.en & running_r;
  assign terminal   = armed & q_zero;
  assign count_step = ~q_zero;
  assign toggle0    = armed & count_step;
  assign d_nonzero  = (bus.d != '0);

  // low_zero[i] is set when bits 0..i-1 are all zero (borrow ripples into bit i)
  always_comb begin
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      low_zero[i] = acc;
      acc         = acc & ~q_r[i];
    end
  end

  // JK stage inputs: load and periodic reload use J/K as set/clear, otherwise J = K = toggle
  always_comb begin
    j_c = '0;
    k_c = '0;
    if (bus.load) begin
      j_c = bus.d;
      k_c = ~bus.d;
    end else if (terminal) begin
      if (bus.periodic) begin
        j_c = bus.d;
        k_c = ~bus.d;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        j_c[i] = toggle0 & low_zero[i];
        k_c[i] = toggle0 & low_zero[i];
      end
    end
  end

  // JK characteristic equation per bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      q_r <= (j_c & ~q_r) | (~k_c & q_r);
    end
  end

  // Armed flag and expiry pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.load) begin
      running_r <= d_nonzero;
      done_r    <= 1'b0;
    end else if (terminal) begin
      running_r <= bus.periodic & d_nonzero;
      done_r    <= 1'b1;
    end else begin
      done_r    <= 1'b0;
    end
  end

  assign bus.q       = q_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;
  assign bus.bo      = q_zero & bus.en & running_r;

endmodule
